fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_perf_cnt.sv | 26 ++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and widths for the fetch controller.
package fetch_ctrl_pkg;

    localparam int TGT_W = 3;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_STALL,
        ST_FLUSH,
        ST_HALT
    } state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating performance counter with synchronous clear and count enable.
module fetch_perf_cnt
    import fetch_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing FSM: load stalls, branch issue with flush slots, halt.
// Performance counters are built only when FETCH_CTRL_PERF_EN is defined.
//
// state | meaning
// IDLE  | out of reset, fetch stalled, waiting for Start
// INIT  | one-cycle PC reset pulse, clears counters and pending branch
// RUN   | normal fetch; handles halt, branch and load requests
// STALL | remaining load-latency cycles, all requests ignored
// FLUSH | squash slots after a taken branch, all requests ignored
// HALT  | program finished, waiting for Start
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_SLOTS = 1
)
(
    input  logic             CLK,
    input  logic             Init_n,
    input  logic             Start,
    input  logic             BranchReq,
    input  logic [TGT_W-1:0] BranchTgt,
    input  logic             LoadReq,
    input  logic             HaltReq,
    output logic             Init,
    output logic             Stall,
    output logic             Branch,
    output logic [TGT_W-1:0] Target,
    output logic             Flush,
    output logic             done,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [3:0] LOAD_CNT  = 4'(LOAD_LAT - 1);
    localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_SLOTS);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_pend;
    logic [TGT_W-1:0] r_tgt;

    logic             w_run;
    logic             w_br;
    logic             w_load;
    logic [3:0]       w_cnt_nxt;

    always_comb begin
        w_run     = (r_state == ST_RUN);
        w_br      = w_run && !HaltReq && (r_pend || (!LoadReq && BranchReq));
        w_load    = w_run && !HaltReq && !r_pend && LoadReq;
        w_cnt_nxt = r_cnt - 4'd1;
    end

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_tgt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (Start) r_state <= ST_INIT;
                ST_INIT: begin
                    r_pend  <= 1'b0;
                    r_tgt   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (HaltReq) begin
                        r_state <= ST_HALT;
                    end else if (w_br) begin
                        r_pend <= 1'b0;
                        if (FLUSH_SLOTS != 0) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= FLUSH_CNT;
                        end
                    end else if (LoadReq) begin
                        // Branch arriving under a load is replayed once the stall ends
                        if (BranchReq) begin
                            r_pend <= 1'b1;
                            r_tgt  <= BranchTgt;
                        end
                        if (LOAD_LAT > 1) begin
                            r_state <= ST_STALL;
                            r_cnt   <= LOAD_CNT;
                        end
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == 4'd0) r_state <= ST_RUN;
                end
                ST_HALT: if (Start) r_state <= ST_INIT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Init   = (r_state == ST_INIT);
        Stall  = (r_state == ST_IDLE) || (r_state == ST_STALL) || w_load;
        Branch = w_br;
        Target = w_br ? (r_pend ? r_tgt : BranchTgt) : '0;
        Flush  = (r_state == ST_FLUSH);
        done   = (r_state == ST_HALT);
    end

`ifdef FETCH_CTRL_PERF_EN
    logic w_clr;
    logic w_cyc_en;
    logic w_stall_en;

    always_comb begin
        w_clr      = (r_state == ST_INIT);
        w_cyc_en   = w_run || (r_state == ST_STALL) || (r_state == ST_FLUSH);
        w_stall_en = Stall && (r_state != ST_IDLE);
    end

    fetch_perf_cnt u_cycle_cnt (
        .i_clk   (CLK),
        .i_rst_n (Init_n),
        .i_clr   (w_clr),
        .i_en    (w_cyc_en),
        .o_cnt   (CycleCnt)
    );

    fetch_perf_cnt u_stall_cnt (
        .i_clk   (CLK),
        .i_rst_n (Init_n),
        .i_clr   (w_clr),
        .i_en    (w_stall_en),
        .o_cnt   (StallCnt)
    );
`else
    assign CycleCnt = '0;
    assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: dut_a uses LOAD_LAT=3, dut_b LOAD_LAT=2, both FLUSH_SLOTS=1.
module tb_fetch_ctrl;

    localparam logic [15:0] ZERO = 16'd0;
    localparam logic [15:0] ONE  = 16'd1;

    logic        CLK = 1'b0;
    logic        Init_n, Start, BranchReq, LoadReq, HaltReq;
    logic [2:0]  BranchTgt;

    logic        a_init, a_stall, a_branch, a_flush, a_done;
    logic [2:0]  a_tgt;
    logic [15:0] a_cyc, a_scnt;
    logic        b_init, b_stall, b_branch, b_flush, b_done;
    logic [2:0]  b_tgt;
    logic [15:0] b_cyc, b_scnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fetch_ctrl #(.LOAD_LAT(3), .FLUSH_SLOTS(1)) dut_a (
        .CLK(CLK), .Init_n(Init_n), .Start(Start), .BranchReq(BranchReq),
        .BranchTgt(BranchTgt), .LoadReq(LoadReq), .HaltReq(HaltReq),
        .Init(a_init), .Stall(a_stall), .Branch(a_branch), .Target(a_tgt),
        .Flush(a_flush), .done(a_done), .CycleCnt(a_cyc), .StallCnt(a_scnt)
    );

    fetch_ctrl #(.LOAD_LAT(2), .FLUSH_SLOTS(1)) dut_b (
        .CLK(CLK), .Init_n(Init_n), .Start(Start), .BranchReq(BranchReq),
        .BranchTgt(BranchTgt), .LoadReq(LoadReq), .HaltReq(HaltReq),
        .Init(b_init), .Stall(b_stall), .Branch(b_branch), .Target(b_tgt),
        .Flush(b_flush), .done(b_done), .CycleCnt(b_cyc), .StallCnt(b_scnt)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic idle_in();
        Start = 0; BranchReq = 0; LoadReq = 0; HaltReq = 0; BranchTgt = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

    initial begin
        Init_n = 0;
        idle_in();
        mid();
        chk("rst_init",   16'(a_init),   ZERO);
        chk("rst_stall",  16'(a_stall),  ONE);
        chk("rst_branch", 16'(a_branch), ZERO);
        chk("rst_target", 16'(a_tgt),    ZERO);
        chk("rst_flush",  16'(a_flush),  ZERO);
        chk("rst_done",   16'(a_done),   ZERO);
        chk("rst_cyc",    a_cyc,         ZERO);
        chk("rst_scnt",   a_scnt,        ZERO);
        nxt(); Init_n = 1;
        mid(); chk("idle_stall", 16'(a_stall), ONE);

        // start -> INIT one cycle -> RUN
        nxt(); Start = 1;
        mid(); chk("idle_noinit", 16'(a_init), ZERO);
        nxt(); Start = 0;
        mid(); chk("init_pulse", 16'(a_init), ONE);
        nxt();
        mid(); chk("run_init0", 16'(a_init), ZERO);
               chk("run_stall0", 16'(a_stall), ZERO);
        nxt();
        mid(); chk("run_init_still0", 16'(a_init), ZERO);

        // single load: A stalls 3 cycles, B stalls 2
        nxt(); LoadReq = 1;
        mid(); chk("ld_a_c1", 16'(a_stall), ONE);
               chk("ld_b_c1", 16'(b_stall), ONE);
        nxt(); LoadReq = 0;
        mid(); chk("ld_a_c2", 16'(a_stall), ONE);
               chk("ld_b_c2", 16'(b_stall), ONE);
        nxt();
        mid(); chk("ld_a_c3", 16'(a_stall), ONE);
               chk("ld_b_c3", 16'(b_stall), ZERO);
        nxt();
        mid(); chk("ld_a_c4", 16'(a_stall), ZERO);

        // branch to 5, one flush slot; requests in FLUSH are ignored
        nxt(); BranchReq = 1; BranchTgt = 3'd5;
        mid(); chk("br_branch", 16'(a_branch), ONE);
               chk("br_target", 16'(a_tgt),    16'd5);
               chk("br_flush0", 16'(a_flush),  ZERO);
        nxt(); BranchTgt = 3'd7;
        mid(); chk("fl_flush",  16'(a_flush),  ONE);
               chk("fl_nobr",   16'(a_branch), ZERO);
               chk("fl_tgt0",   16'(a_tgt),    ZERO);
        nxt(); idle_in();
        mid(); chk("fl_done",   16'(a_flush),  ZERO);
               chk("fl_run_stall", 16'(a_stall), ZERO);

        // load + branch(3): B issues after 2 stall cycles, A after 3
        nxt(); LoadReq = 1; BranchReq = 1; BranchTgt = 3'd3;
        mid(); chk("lb_b_stall1", 16'(b_stall),  ONE);
               chk("lb_b_nobr",   16'(b_branch), ZERO);
               chk("lb_b_tgt0",   16'(b_tgt),    ZERO);
        nxt(); idle_in();
        mid(); chk("lb_b_stall2", 16'(b_stall),  ONE);
               chk("lb_b_nobr2",  16'(b_branch), ZERO);
        nxt();
        mid(); chk("lb_b_stall0", 16'(b_stall),  ZERO);
               chk("lb_b_branch", 16'(b_branch), ONE);
               chk("lb_b_target", 16'(b_tgt),    16'd3);
               chk("lb_a_stall3", 16'(a_stall),  ONE);
               chk("lb_a_nobr",   16'(a_branch), ZERO);
        nxt();
        mid(); chk("lb_b_flush",  16'(b_flush),  ONE);
               chk("lb_a_branch", 16'(a_branch), ONE);
               chk("lb_a_target", 16'(a_tgt),    16'd3);
        nxt();
        mid(); chk("lb_a_flush",  16'(a_flush),  ONE);
               chk("lb_b_run",    16'(b_branch), ZERO);
        nxt();
        mid(); chk("lb_a_run",    16'(a_flush),  ZERO);

        // halt beats branch, Start restarts from HALT
        nxt(); HaltReq = 1; BranchReq = 1; BranchTgt = 3'd6;
        mid(); chk("h_nobr",   16'(a_branch), ZERO);
               chk("h_tgt0",   16'(a_tgt),    ZERO);
               chk("h_stall0", 16'(a_stall),  ZERO);
               chk("h_flush0", 16'(a_flush),  ZERO);
        nxt(); idle_in();
        mid(); chk("h_done",    16'(a_done),  ONE);
               chk("h_stall",   16'(a_stall), ZERO);
        nxt(); Start = 1;
        mid(); chk("h_done2",   16'(a_done),  ONE);
        nxt(); Start = 0;
        mid(); chk("h_reinit",  16'(a_init),  ONE);
               chk("h_done0",   16'(a_done),  ZERO);
        nxt();

        // reset in the middle of a load stall with a pending branch
        nxt(); LoadReq = 1; BranchReq = 1; BranchTgt = 3'd4;
        nxt(); idle_in();
        mid(); chk("r_in_stall", 16'(a_stall), ONE);
        nxt(); Init_n = 0;
        mid(); chk("r_idle_stall", 16'(a_stall),  ONE);
               chk("r_idle_nobr",  16'(a_branch), ZERO);
               chk("r_cyc0",       a_cyc,          ZERO);
               chk("r_scnt0",      a_scnt,         ZERO);
        nxt(); Init_n = 1;
        nxt(); Start = 1;
        nxt(); Start = 0;
        nxt();
        mid(); chk("r_run_nobr",  16'(a_branch), ZERO);
               chk("r_run_tgt0",  16'(a_tgt),    ZERO);
               chk("r_run_stall", 16'(a_stall),  ZERO);
               chk("r_run_cyc",   a_cyc,          ZERO);
               chk("r_run_scnt",  a_scnt,         ZERO);
        nxt();
        mid(); chk("r_run2_nobr", 16'(a_branch), ZERO);
`ifdef FETCH_CTRL_PERF_EN
               chk("r_run2_cyc",  a_cyc,  ONE);
`else
               chk("r_run2_cyc",  a_cyc,  ZERO);
`endif
               chk("r_run2_scnt", a_scnt, ZERO);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
